// File: rtl/data_memory_arbiter_pkg.sv
// Shared types and helpers for the two-port data memory arbiter.
// The FSM state enum, port/word sizing and the address legality check.
package data_memory_arbiter_pkg;

  localparam int NUM_PORTS = 2;
  localparam int WORD_BITS = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  // Word-aligned and inside the attached memory.
  function automatic logic addr_legal(input logic [WORD_BITS-1:0] addr,
                                      input int unsigned depth_words);
    logic [WORD_BITS-1:0] word_idx;
    word_idx   = {2'b00, addr[WORD_BITS-1:2]};
    addr_legal = (addr[1:0] == 2'b00) && (word_idx < WORD_BITS'(depth_words));
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester combinational arbiter: a lone requester always wins,
// a tie goes to the port named by the priority pointer.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       prio,
  output logic [1:0] grant
);

  always_comb begin
    grant    = 2'b00;
    grant[0] = req[0] & (~req[1] | ~prio);
    grant[1] = req[1] & (~req[0] |  prio);
  end

endmodule

// File: rtl/data_memory_arbiter.sv
// Arbitrates a CPU port and a DMA/debug port onto one data_memory with a
// fixed three-cycle IDLE -> ACCESS -> RESP transfer and alternating priority.
module data_memory_arbiter
  import data_memory_arbiter_pkg::*;
#(
  parameter int DEPTH_WORDS    = 64,
  parameter int RESET_PRIORITY = 0
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [1:0]                p_req,
  input  logic [1:0]                p_we,
  input  logic [1:0][WORD_BITS-1:0] p_address,
  input  logic [1:0][WORD_BITS-1:0] p_write_data,
  output logic [1:0]                p_ack,
  output logic                      p_err,
  output logic [WORD_BITS-1:0]      p_read_data,
  output logic                      mem_we,
  output logic [WORD_BITS-1:0]      mem_address,
  output logic [WORD_BITS-1:0]      mem_write_data,
  input  logic [WORD_BITS-1:0]      mem_read_data
);

  // Handshake: a port raises p_req with stable operands and holds them until
  // its one-cycle p_ack; operands are captured once, when the request is
  // sampled in IDLE, and a p_req still high after the ack counts as a new request.

  state_e               state_q, state_d;
  logic                 prio_q, prio_d;
  logic                 owner_q, owner_d;
  logic                 we_q, we_d;
  logic [WORD_BITS-1:0] addr_q, addr_d;
  logic [WORD_BITS-1:0] wdata_q, wdata_d;
  logic [1:0]           ack_q, ack_d;
  logic                 err_q, err_d;
  logic [WORD_BITS-1:0] rdata_q, rdata_d;

  logic [1:0] grant;
  logic       winner;
  logic       legal;
  logic       in_access;

  rr_arbiter2 u_arb (
    .req   (p_req),
    .prio  (prio_q),
    .grant (grant)
  );

  assign winner    = grant[1];
  assign legal     = addr_legal(addr_q, DEPTH_WORDS);
  assign in_access = (state_q == ACCESS);

  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    owner_d = owner_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ack_d   = 2'b00;
    err_d   = 1'b0;
    rdata_d = '0;
    case (state_q)
      IDLE: begin
        if (|p_req) begin
          state_d = ACCESS;
          owner_d = winner;
          we_d    = p_we[winner];
          addr_d  = p_address[winner];
          wdata_d = p_write_data[winner];
          prio_d  = ~winner;
        end
      end
      ACCESS: begin
        state_d = RESP;
        ack_d   = owner_q ? 2'b10 : 2'b01;
        err_d   = ~legal;
        rdata_d = (legal && !we_q) ? mem_read_data : '0;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      prio_q  <= 1'(RESET_PRIORITY);
      owner_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ack_q   <= 2'b00;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Reset gates the store and the response in the same cycle it is raised.
  assign mem_we         = in_access & we_q & legal & ~reset;
  assign mem_address    = in_access ? addr_q : '0;
  assign mem_write_data = in_access ? wdata_q : '0;
  assign p_ack          = reset ? 2'b00 : ack_q;
  assign p_err          = err_q & ~reset;
  assign p_read_data    = reset ? '0 : rdata_q;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Directed bench for data_memory_arbiter with a behavioural 64-word data_memory.
module tb_data_memory_arbiter;
  import data_memory_arbiter_pkg::*;

  logic             clock;
  logic             reset;
  logic [1:0]       p_req;
  logic [1:0]       p_we;
  logic [1:0][31:0] p_address;
  logic [1:0][31:0] p_write_data;
  logic [1:0]       p_ack;
  logic             p_err;
  logic [31:0]      p_read_data;
  logic             mem_we;
  logic [31:0]      mem_address;
  logic [31:0]      mem_write_data;
  logic [31:0]      mem_read_data;

  int tests_run    = 0;
  int tests_failed = 0;

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  data_memory_arbiter #(
    .DEPTH_WORDS    (64),
    .RESET_PRIORITY (0)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .p_req          (p_req),
    .p_we           (p_we),
    .p_address      (p_address),
    .p_write_data   (p_write_data),
    .p_ack          (p_ack),
    .p_err          (p_err),
    .p_read_data    (p_read_data),
    .mem_we         (mem_we),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data)
  );

  // data_memory model: combinational read, write on posedge; a preload port for setup
  logic [31:0] mem [0:63];
  logic        pre_we;
  logic [5:0]  pre_idx;
  logic [31:0] pre_data;

  assign mem_read_data = mem[mem_address[7:2]];

  always @(posedge clock) begin
    if (pre_we) mem[pre_idx] <= pre_data;
    else if (mem_we) mem[mem_address[7:2]] <= mem_write_data;
  end

  // driver tasks
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic poke(input logic [5:0] idx, input logic [31:0] data);
    pre_we   = 1'b1;
    pre_idx  = idx;
    pre_data = data;
    tick();
    pre_we   = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    reset        = 1'b1;
    p_req        = 2'b00;
    p_we         = 2'b00;
    p_address    = '0;
    p_write_data = '0;
    pre_we       = 1'b0;
    pre_idx      = '0;
    pre_data     = '0;

    poke(6'd0, 32'd100);
    poke(6'd1, 32'd111);
    poke(6'd2, 32'd300);
    poke(6'd3, 32'd400);
    tick();

    // reset state
    check("rst_ack", {30'b0, p_ack}, 32'h0);
    check("rst_err", {31'b0, p_err}, 32'h0);
    check("rst_rdata", p_read_data, 32'h0);
    check("rst_mem_we", {31'b0, mem_we}, 32'h0);
    check("rst_mem_addr", mem_address, 32'h0);
    check("rst_state", 32'(dut.state_q), 32'(IDLE));
    reset = 1'b0;
    tick();

    // port 0 load from 0x8
    p_req = 2'b01; p_we[0] = 1'b0; p_address[0] = 32'h8;
    tick();
    check("s1_acc_we", {31'b0, mem_we}, 32'h0);
    check("s1_acc_addr", mem_address, 32'h8);
    check("s1_acc_ack", {30'b0, p_ack}, 32'h0);
    tick();
    check("s1_resp_ack", {30'b0, p_ack}, 32'h1);
    check("s1_resp_rdata", p_read_data, 32'd300);
    check("s1_resp_err", {31'b0, p_err}, 32'h0);
    check("s1_resp_we", {31'b0, mem_we}, 32'h0);
    p_req = 2'b00;
    tick();
    check("s1_idle_ack", {30'b0, p_ack}, 32'h0);
    check("s1_idle_rdata", p_read_data, 32'h0);

    // port 1 store 0xDEADBEEF to 0x14, then port 0 reads it back
    p_req = 2'b10; p_we[1] = 1'b1; p_address[1] = 32'h14; p_write_data[1] = 32'hDEAD_BEEF;
    tick();
    check("s2_acc_we", {31'b0, mem_we}, 32'h1);
    check("s2_acc_addr", mem_address, 32'h14);
    check("s2_acc_wdata", mem_write_data, 32'hDEAD_BEEF);
    tick();
    check("s2_resp_we", {31'b0, mem_we}, 32'h0);
    check("s2_resp_ack", {30'b0, p_ack}, 32'h2);
    check("s2_resp_err", {31'b0, p_err}, 32'h0);
    check("s2_resp_rdata", p_read_data, 32'h0);
    p_req = 2'b00;
    tick();
    check("s2_mem5", mem[5], 32'hDEAD_BEEF);
    p_req = 2'b01; p_we[0] = 1'b0; p_address[0] = 32'h14;
    tick();
    tick();
    check("s2_rd_ack", {30'b0, p_ack}, 32'h1);
    check("s2_rd_rdata", p_read_data, 32'hDEAD_BEEF);
    p_req = 2'b00;
    tick();

    // both ports held from reset: grants alternate 0,1,0,1
    reset = 1'b1;
    tick();
    reset = 1'b0;
    p_req = 2'b11; p_we = 2'b00; p_address[0] = 32'h8; p_address[1] = 32'hC;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("s3_addr_%0d", i), mem_address, (i % 2 == 1) ? 32'hC : 32'h8);
      tick();
      check($sformatf("s3_ack_%0d", i), {30'b0, p_ack}, (i % 2 == 1) ? 32'h2 : 32'h1);
      check($sformatf("s3_rdata_%0d", i), p_read_data, (i % 2 == 1) ? 32'd400 : 32'd300);
      if (i == 3) p_req = 2'b00;
      tick();
      check($sformatf("s3_gap_%0d", i), {30'b0, p_ack}, 32'h0);
    end

    // illegal: port 0 misaligned load, port 1 out-of-range store
    p_req = 2'b11; p_we = 2'b10; p_address[0] = 32'h6; p_address[1] = 32'h100;
    p_write_data[1] = 32'h0000_0BAD;
    tick();
    check("s4_p0_we", {31'b0, mem_we}, 32'h0);
    check("s4_p0_addr", mem_address, 32'h6);
    tick();
    check("s4_p0_ack", {30'b0, p_ack}, 32'h1);
    check("s4_p0_err", {31'b0, p_err}, 32'h1);
    check("s4_p0_rdata", p_read_data, 32'h0);
    p_req = 2'b10;
    tick();
    check("s4_gap_ack", {30'b0, p_ack}, 32'h0);
    tick();
    check("s4_p1_we", {31'b0, mem_we}, 32'h0);
    tick();
    check("s4_p1_ack", {30'b0, p_ack}, 32'h2);
    check("s4_p1_err", {31'b0, p_err}, 32'h1);
    check("s4_p1_rdata", p_read_data, 32'h0);
    p_req = 2'b00;
    tick();
    check("s4_mem0", mem[0], 32'd100);
    check("s4_mem1", mem[1], 32'd111);

    // reset during the ACCESS of a store to 0x0
    p_req = 2'b01; p_we[0] = 1'b1; p_address[0] = 32'h0; p_write_data[0] = 32'h55;
    tick();
    reset = 1'b1;
    #1;
    check("s5_acc_we", {31'b0, mem_we}, 32'h0);
    tick();
    reset = 1'b0;
    p_req = 2'b00;
    check("s5_state", 32'(dut.state_q), 32'(IDLE));
    check("s5_ack", {30'b0, p_ack}, 32'h0);
    check("s5_mem0", mem[0], 32'd100);
    tick();
    check("s5_ack_late", {30'b0, p_ack}, 32'h0);
    tick();
    check("s5_ack_later", {30'b0, p_ack}, 32'h0);
    check("s5_mem0_late", mem[0], 32'd100);

    // port 0 holds p_req across its ack while port 1 waits -> port 1 next
    p_req = 2'b01; p_we = 2'b00; p_address[0] = 32'h8; p_address[1] = 32'hC;
    tick();
    p_req = 2'b11;
    tick();
    check("s6_first_ack", {30'b0, p_ack}, 32'h1);
    tick();
    check("s6_gap_ack", {30'b0, p_ack}, 32'h0);
    tick();
    check("s6_second_addr", mem_address, 32'hC);
    tick();
    check("s6_second_ack", {30'b0, p_ack}, 32'h2);
    check("s6_second_rdata", p_read_data, 32'd400);
    p_req = 2'b00;
    tick();
    check("s6_idle_ack", {30'b0, p_ack}, 32'h0);

    // final report
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
